// File: rtl/multi_layer_composer.sv
// rtl/multi_layer_composer.sv - display composer: scaled/interlaced counters and layer/sprite merge
// Optional sticky sprite/layer collision flags: define COMPOSER_COLLISION_EN.
module multi_layer_composer #(
    parameter int NUM_LAYERS = 2,
    parameter int PIX_W      = 8,
    parameter int Z_W        = 2,
    parameter int FRAC_BITS  = 7,
    parameter int HRES       = 640,
    parameter int VRES       = 480
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        interlaced,
    input  logic [7:0]                  frac_x_incr,
    input  logic [7:0]                  frac_y_incr,
    input  logic [PIX_W-1:0]            border_color,
    input  logic [9:0]                  active_hstart,
    input  logic [9:0]                  active_hstop,
    input  logic [8:0]                  active_vstart,
    input  logic [8:0]                  active_vstop,
    input  logic [8:0]                  irqline,
    input  logic [NUM_LAYERS-1:0]       layer_enable,
    input  logic                        sprites_enabled,
    input  logic [NUM_LAYERS*PIX_W-1:0] layer_lb_rddata,
    input  logic [PIX_W+Z_W-1:0]        sprite_lb_rddata,
    input  logic                        display_next_frame,
    input  logic                        display_next_line,
    input  logic                        display_next_pixel,
    input  logic                        display_current_field,
    output logic                        current_field,
    output logic                        line_irq,
    output logic [8:0]                  scanline,
    output logic [8:0]                  line_idx,
    output logic                        line_render_start,
    output logic [9:0]                  lb_rdidx,
    output logic                        sprite_lb_erase_start,
    output logic [PIX_W-1:0]            display_data,
    output logic [NUM_LAYERS-1:0]       sprite_collision
);

    localparam int SY_W = 9 + FRAC_BITS;
    localparam int SX_W = 10 + FRAC_BITS;
    localparam logic [8:0] VRES_L = 9'(VRES);
    localparam logic [9:0] HRES_L = 10'(HRES);

    logic [9:0]       y_counter;
    logic [9:0]       y_delayed;
    logic [10:0]      x_counter;
    logic             line_pending;
    logic             started;
    logic [SY_W-1:0]  scaled_y;
    logic [SX_W-1:0]  scaled_x;
    logic             display_active;

    logic [9:0]       y_next;
    logic [10:0]      x_step;
    logic             irq_match;
    logic [9:0]       x;
    logic             hactive;
    logic             vactive;
    logic [8:0]       y_inc;
    logic [7:0]       x_inc;
    logic [PIX_W-1:0] sp_col;
    logic [Z_W-1:0]   sp_z;
    logic             sprite_vis;
    logic [PIX_W-1:0] composed;

    always_comb begin
        y_next    = y_counter + (interlaced ? 10'd2 : 10'd1);
        x_step    = interlaced ? 11'd1 : 11'd2;
        // Interlaced fields cover alternate lines, so only the line-pair index is compared
        irq_match = interlaced ? (y_next[9:1] == irqline[8:1]) : (y_next == {1'b0, irqline});
        x         = x_counter[10:1];
        hactive   = (x >= active_hstart) && (x < active_hstop);
        vactive   = (y_delayed >= {1'b0, active_vstart}) && (y_delayed < {1'b0, active_vstop});
        y_inc     = interlaced ? {frac_y_incr, 1'b0} : {1'b0, frac_y_incr};
        x_inc     = interlaced ? {1'b0, frac_x_incr[7:1]} : frac_x_incr;
    end

    assign scanline              = y_delayed[9] ? 9'd511 : y_counter[8:0];
    assign line_idx              = scaled_y[SY_W-1:FRAC_BITS];
    assign lb_rdidx              = scaled_x[SX_W-1:FRAC_BITS];
    assign sprite_lb_erase_start = (x_counter == {10'd639, interlaced});

    // Bottom-up painter: sprite at depth k+1 goes under layer k; deep z sits on top of everything
    always_comb begin
        sp_col     = sprite_lb_rddata[PIX_W-1:0];
        sp_z       = sprite_lb_rddata[PIX_W+Z_W-1:PIX_W];
        sprite_vis = sprites_enabled && (sp_col != '0) && (sp_z != '0);
        composed   = '0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            if (sprite_vis && int'(sp_z) == k + 1)
                composed = sp_col;
            if (layer_enable[k] && layer_lb_rddata[k*PIX_W +: PIX_W] != '0)
                composed = layer_lb_rddata[k*PIX_W +: PIX_W];
        end
        if (sprite_vis && int'(sp_z) >= NUM_LAYERS + 1)
            composed = sp_col;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_counter         <= '0;
            y_delayed         <= '0;
            x_counter         <= '0;
            current_field     <= 1'b0;
            line_irq          <= 1'b0;
            line_pending      <= 1'b0;
            started           <= 1'b0;
            scaled_y          <= '0;
            scaled_x          <= '0;
            line_render_start <= 1'b0;
            display_active    <= 1'b0;
            display_data      <= '0;
        end else begin
            line_irq          <= 1'b0;
            line_render_start <= 1'b0;
            line_pending      <= display_next_line && !display_next_frame;

            if (display_next_frame) begin
                y_counter     <= (interlaced && !display_current_field) ? 10'd1 : 10'd0;
                current_field <= !display_current_field;
            end else if (display_next_line) begin
                y_delayed <= y_counter;
                y_counter <= y_next;
                line_irq  <= irq_match;
            end

            if (display_next_line)
                x_counter <= '0;
            else if (display_next_pixel)
                x_counter <= x_counter + x_step;

            if (display_next_line)
                scaled_x <= '0;
            else if (display_next_pixel && hactive && scaled_x[SX_W-1:FRAC_BITS] < HRES_L)
                scaled_x <= scaled_x + SX_W'(x_inc);

            // Scaled y steps one cycle after the line strobe so y_delayed already reflects the new line
            if (line_pending) begin
                if (!started && y_counter >= {1'b0, active_vstart}) begin
                    scaled_y          <= (interlaced && (current_field ^ active_vstart[0])) ?
                                         SY_W'(frac_y_incr) : '0;
                    started           <= 1'b1;
                    line_render_start <= 1'b1;
                end else if (scaled_y[SY_W-1:FRAC_BITS] < VRES_L && vactive) begin
                    scaled_y          <= scaled_y + SY_W'(y_inc);
                    line_render_start <= 1'b1;
                end
            end
            if (display_next_frame)
                started <= 1'b0;

            display_active <= hactive && vactive;
            display_data   <= display_active ? composed : border_color;
        end
    end

`ifdef COMPOSER_COLLISION_EN
    logic [NUM_LAYERS-1:0] collision;
    logic [NUM_LAYERS-1:0] hit;

    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_LAYERS; i++)
            hit[i] = display_active && sprite_vis && layer_enable[i] &&
                     (layer_lb_rddata[i*PIX_W +: PIX_W] != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            collision <= '0;
        else
            collision <= (display_next_frame ? '0 : collision) | hit;
    end

    assign sprite_collision = collision;
`else
    assign sprite_collision = '0;
`endif

endmodule

// File: doc/multi_layer_composer.md
Name: multi_layer_composer

Overview:
Parametrised next-generation display composer. Generates horizontal/vertical, scaled and interlace-aware line/pixel counters. Drives the render engines and line-buffer reads, and merges NUM_LAYERS tile/bitmap layers plus one sprite plane into a registered output pixel. Sits between the layer/sprite renderers and the video timing/DAC front end.

Parameters:
NUM_LAYERS, 2, number of tile/bitmap layers (1..4); layer 0 is bottom-most.
PIX_W, 8, palette index width.
Z_W, 2, sprite depth field width; must satisfy 2**Z_W >= NUM_LAYERS+2.
FRAC_BITS, 7, fractional bits of the scale counters.
HRES, 640, scaled horizontal clamp.
VRES, 480, scaled vertical clamp.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
interlaced  in  1  interlaced timing mode
frac_x_incr  in  8  horizontal scale step (unit = 2**FRAC_BITS)
frac_y_incr  in  8  vertical scale step
border_color  in  PIX_W  colour outside active window
active_hstart / active_hstop  in  10  active window, x
active_vstart / active_vstop  in  9  active window, y
irqline  in  9  line interrupt compare
layer_enable  in  NUM_LAYERS  per-layer enable
sprites_enabled  in  1  sprite plane enable
layer_lb_rddata  in  NUM_LAYERS*PIX_W  flat bus, layer i at [i*PIX_W +: PIX_W]
sprite_lb_rddata  in  PIX_W+Z_W  {z, colour}
display_next_frame / display_next_line / display_next_pixel  in  1  timing strobes
display_current_field  in  1  field from timing generator
current_field  out  1  registered field
line_irq  out  1  one-cycle pulse
scanline  out  9  current line, pegged at 511
line_idx  out  9  scaled line to render
line_render_start  out  1  one-cycle render request
lb_rdidx  out  10  scaled line-buffer read index
sprite_lb_erase_start  out  1  sprite buffer clear strobe
display_data  out  PIX_W  composed pixel, registered
sprite_collision  out  NUM_LAYERS  sticky collision flags (see optional feature)

Behaviour:
- Reset values: all outputs, counters and flags 0; display_data 0.
- y_counter (10b) on next_line: +2 if interlaced, else +1. Previous value is copied into y_delayed.
- On next_frame, y_counter loads 1 if (interlaced && !display_current_field), else 0. next_frame beats a same-cycle next_line. current_field <= !display_current_field.
- line_irq is registered: 1 in the cycle after next_line when y_counter == irqline (progressive) or y_counter[9:1] == irqline[8:1] (interlaced).
- x_counter (11b, half-pixel units) on next_pixel: +2 progressive, +1 interlaced. next_line clears it and wins. x = x_counter[10:1].
- scanline = 511 if y_delayed[9], else y_counter[8:0].
- sprite_lb_erase_start is combinational: x_counter == {10'd639, interlaced}.
- hactive = x in [hstart, hstop); vactive = y_delayed in [vstart, vstop). display_active is registered as hactive && vactive.
- Scaled y (9+FRAC_BITS bits), evaluated the cycle after next_line:
  - First line with y_counter >= vstart in the frame: load frac_y_incr if (interlaced && current_field ^ vstart[0]), else 0. Set started; pulse line_render_start.
  - Else, if scaled_y < VRES && vactive: add frac_y_incr (<<1 when interlaced) and pulse line_render_start.
  - next_frame clears started.
- Scaled x: on next_pixel && hactive && scaled_x < HRES, add frac_x_incr (>>1 when interlaced). next_line clears it. Scaled x saturates by stopping at the HRES clamp; it never wraps.
- Composition runs every clk and is registered (1-cycle latency after display_active):
  - Inactive: border_color.
  - Active: start at 0. For k = 0..NUM_LAYERS:
    - Sprite with z == k+1, sprites_enabled and colour != 0 overwrites.
    - Then layer k (if k < NUM_LAYERS), when enabled and != 0, overwrites.
  - z == 0 hides the sprite. z > NUM_LAYERS+1 is treated as top-most.

Optional Feature:
COMPOSER_COLLISION_EN.
- Defined: during display_active, any opaque enabled sprite pixel coinciding with an opaque enabled layer i sets sprite_collision[i]. Flags are sticky and cleared on next_frame; set beats clear in the same cycle.
- Undefined: sprite_collision tied to 0 and no logic is generated.

Test Plan:
- NUM_LAYERS=2, active, layer0=0x11, layer1=0, sprite {z=2, 0x33} -> display_data 0x33 one clk later; same with z=1 -> 0x11.
- NUM_LAYERS=3, all layers 0x05/0x06/0x07, sprite z=4 colour 0x09 -> 0x09; layer_enable=3'b000, sprite z=0 -> 0x00; pixel outside window -> border_color 0xA5.
- frac_x_incr=64 (0.5x), progressive -> lb_rdidx advances 1 every 2 pixels, clamps at 640; next_line -> 0.
- interlaced, display_current_field=0, next_frame -> y_counter=1, current_field=1; irqline=5 -> line_irq pulses on y_counter=5.
- next_frame and next_line in the same cycle -> y_counter reloads (0/1), no increment; assert rst mid-line -> all outputs 0 immediately.
- COMPOSER_COLLISION_EN: sprite 0x22 over layer1 0x10 -> sprite_collision=2'b10, held until next_frame, then 0.
